// File: rtl/leddc_pkg.sv
// Shared types and widths for the LEDDC serial feeder and its bench monitor.
package leddc_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned BIT_CNT_W = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/leddc_word_fifo.sv
// Small synchronous word FIFO; the head word is presented straight from the storage flops.
module leddc_word_fifo
  import leddc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  word_t push_data,
  input  logic  pop,
  output word_t pop_data,
  output logic  full,
  output logic  empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/leddc_feeder.sv
// Feeds 16-bit grayscale words LSB-first onto the LED driver's DCK/DAI/DEN port,
// with a one-DCK-period DEN-low gap after every frame.
module leddc_feeder
  import leddc_pkg::*;
#(
  parameter int unsigned WORDS_PER_FRAME = 256,
  parameter int unsigned DCK_DIV         = 2,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                               CLK,
  input  logic                               rst_n,
  input  logic [WORD_W-1:0]                  in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic                               DCK,
  output logic                               DAI,
  output logic                               DEN,
  output logic                               busy,
  output logic                               frame_done,
  output logic [$clog2(WORDS_PER_FRAME)-1:0] word_cnt
);

  localparam int unsigned DIV_W = (DCK_DIV > 1) ? $clog2(DCK_DIV) : 1;
  localparam int unsigned WC_W  = $clog2(WORDS_PER_FRAME);

  logic [DIV_W-1:0]     div_cnt;
  logic                 dck_toggle_c;
  logic                 fall_slot_c;

  feeder_state_t        state;
  feeder_state_t        state_n;
  word_t                shreg;
  word_t                shreg_n;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt_n;
  logic [BIT_CNT_W-1:0] bit_nxt;
  logic [WC_W-1:0]      word_cnt_n;
  logic                 dai_n;
  logic                 den_n;
  logic                 frame_done_n;
  logic                 last_bit;
  logic                 last_word;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  word_t                fifo_head;

  leddc_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (rst_n),
    .push     (in_valid),
    .push_data(in_data),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign busy     = !fifo_empty || (state == SHIFT);

  // Free-running DCK divider; DAI/DEN only move on the edge that drops DCK.
  assign dck_toggle_c = (div_cnt == DIV_W'(DCK_DIV - 1));
  assign fall_slot_c  = dck_toggle_c && DCK;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      DCK     <= 1'b0;
    end else if (dck_toggle_c) begin
      div_cnt <= '0;
      DCK     <= ~DCK;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bit_cnt_n    = bit_cnt;
    word_cnt_n   = word_cnt;
    dai_n        = DAI;
    den_n        = DEN;
    frame_done_n = 1'b0;
    fifo_pop     = 1'b0;
    bit_nxt      = bit_cnt + BIT_CNT_W'(1);
    last_bit     = (bit_cnt == BIT_CNT_W'(WORD_W - 1));
    last_word    = (word_cnt == WC_W'(WORDS_PER_FRAME - 1));

    if (fall_slot_c) begin
      unique case (state)
        // The fall slot that closes the frame gap is also the first chance to
        // start the next word, so the gap lasts exactly one DCK period.
        IDLE, GAP: begin
          state_n = IDLE;
          dai_n   = 1'b0;
          den_n   = 1'b0;
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shreg_n   = fifo_head;
            dai_n     = fifo_head[0];
            den_n     = 1'b1;
            bit_cnt_n = '0;
            state_n   = SHIFT;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            bit_cnt_n = bit_nxt;
            dai_n     = shreg[bit_nxt];
          end else if (last_word) begin
            word_cnt_n   = '0;
            frame_done_n = 1'b1;
            dai_n        = 1'b0;
            den_n        = 1'b0;
            state_n      = GAP;
          end else begin
            word_cnt_n = word_cnt + WC_W'(1);
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              shreg_n   = fifo_head;
              dai_n     = fifo_head[0];
              bit_cnt_n = '0;
            end else begin
              dai_n   = 1'b0;
              den_n   = 1'b0;
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      DAI        <= 1'b0;
      DEN        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      word_cnt   <= word_cnt_n;
      DAI        <= dai_n;
      DEN        <= den_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_leddc_feeder.sv
// Self-checking bench for leddc_feeder: a DCK-rise monitor rebuilds words from DAI/DEN
// and scores them against the queue of accepted words.
module tb_leddc_feeder;
  import leddc_pkg::*;

  localparam int unsigned WPF   = 4;
  localparam int unsigned DIV   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WC_W  = $clog2(WPF);

  logic            CLK = 1'b0;
  logic            rst_n;
  logic [15:0]     in_data;
  logic            in_valid;
  logic            in_ready;
  logic            DCK;
  logic            DAI;
  logic            DEN;
  logic            busy;
  logic            frame_done;
  logic [WC_W-1:0] word_cnt;

  leddc_feeder #(
    .WORDS_PER_FRAME(WPF),
    .DCK_DIV        (DIV),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .DCK       (DCK),
    .DAI       (DAI),
    .DEN       (DEN),
    .busy      (busy),
    .frame_done(frame_done),
    .word_cnt  (word_cnt)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [15:0] exp_q[$];
  int          gap_log[$];
  int          mon_idx = 0;
  int          words_out = 0;
  int          words_in_frame = 0;
  int          gap_cnt = 0;
  int          fd_seen = 0;
  int          exp_fd = 0;
  bit          frame_end_pending = 0;
  bit          dck_prev = 0;
  bit          fd_prev = 0;
  bit          den_prev = 0;
  logic [15:0] mon_word = '0;
  logic [15:0] mon_arrival = '0;
  logic [15:0] last_arrival = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout, want event", name);
  endtask

  // Reference view: each DEN-high DCK rise carries the next bit, LSB first.
  task automatic on_rise();
    logic [15:0] exp_w;
    check("word_cnt", 32'(word_cnt), 32'(words_in_frame));
    if (DEN) begin
      if (mon_idx == 0) begin
        if (frame_end_pending) check("frame_gap_present", 32'(gap_cnt != 0), 32'd1);
        gap_log.push_back(gap_cnt);
        gap_cnt = 0;
        frame_end_pending = 0;
      end
      mon_word[mon_idx] = DAI;
      mon_arrival = {mon_arrival[14:0], DAI};
      mon_idx++;
      if (mon_idx == 16) begin
        mon_idx = 0;
        last_arrival = mon_arrival;
        words_out++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_word: got 0x%0h, want none", mon_word);
        end else begin
          exp_w = exp_q.pop_front();
          check("word_data", 32'(mon_word), 32'(exp_w));
        end
        words_in_frame++;
        if (words_in_frame == WPF) begin
          words_in_frame = 0;
          exp_fd++;
          frame_end_pending = 1;
        end
      end
    end else begin
      if (mon_idx != 0) begin
        check("den_mid_word", 32'(mon_idx), 32'd0);
        mon_idx = 0;
      end
      gap_cnt++;
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial forever begin
    @(negedge CLK);
    if (!rst_n) begin
      mon_idx = 0;
      words_in_frame = 0;
      gap_cnt = 0;
      frame_end_pending = 0;
      dck_prev = 0;
      fd_prev = 0;
      den_prev = 0;
    end else begin
      if (frame_done) begin
        fd_seen++;
        check("frame_done_width", 32'(fd_prev), 32'd0);
        check("frame_done_den_fall", 32'({den_prev, DEN}), 32'b10);
      end
      if (DCK && !dck_prev) on_rise();
      dck_prev = DCK;
      fd_prev = frame_done;
      den_prev = DEN;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1);
  end

  task automatic push(input logic [15:0] d, output int acc_cyc);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    acc_cyc = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!ok && n < 2000) begin
      @(negedge CLK);
      ok = in_ready;
      @(posedge CLK);
      #1;
      n++;
    end
    if (ok) begin
      exp_q.push_back(d);
      acc_cyc = cyc;
    end else begin
      fail_msg("push_timeout");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_words(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (words_out < target && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (words_out < target) fail_msg(name);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge CLK);
    #2 rst_n = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [15:0] data;
    logic [15:0] arrival;
    int          wcnt;
    int          fd;
  } vec_t;

  vec_t tbl[5];
  int   acc, fd0, lat, w0, w1, k;
  int   acc_t[6];

  initial begin
    // arrival: first bit on the wire in [15]
    tbl[0] = '{16'hA5C3, 16'b1100_0011_1010_0101, 1, 0};
    tbl[1] = '{16'h0001, 16'b1000_0000_0000_0000, 2, 0};
    tbl[2] = '{16'h8000, 16'b0000_0000_0000_0001, 3, 0};
    tbl[3] = '{16'h1234, 16'b0010_1100_0100_1000, 0, 1};
    tbl[4] = '{16'hFF00, 16'b0000_0000_1111_1111, 1, 0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge CLK);
    check("rst_dck", 32'(DCK), 32'd0);
    check("rst_dai", 32'(DAI), 32'd0);
    check("rst_den", 32'(DEN), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b1;
    @(posedge CLK); #1;
    check("dck_first_edge", 32'(DCK), 32'd0);
    @(posedge CLK); #1;
    check("dck_first_rise", 32'(DCK), 32'd1);

    // Isolated words, each followed by an underrun.
    gap_log.delete();
    for (int i = 0; i < 5; i++) begin
      fd0 = fd_seen;
      w0 = words_out;
      push(tbl[i].data, acc);
      in_valid = 1'b0;
      lat = 0;
      while (!DEN && lat < 20) begin
        @(posedge CLK); #1;
        lat++;
      end
      check("push_to_den", 32'(lat >= 1 && lat <= 2 * DIV + 1), 32'd1);
      wait_words(w0 + 1, 300, "single_word_timeout");
      repeat (DIV + 1) @(negedge CLK);
      check("lsb_first_order", 32'(last_arrival), 32'(tbl[i].arrival));
      check("den_low_after_word", 32'(DEN), 32'd0);
      check("word_cnt_after", 32'(word_cnt), 32'(tbl[i].wcnt));
      check("frame_done_pulses", 32'(fd_seen - fd0), 32'(tbl[i].fd));
      check("busy_idle", 32'(busy), 32'd0);
      idle(8);
    end
    check("underrun_gap", 32'(gap_log.size() >= 2 && gap_log[1] > 0), 32'd1);

    // Continuous stream across two frames.
    do_reset();
    gap_log.delete();
    fd0 = fd_seen;
    w0 = words_out;
    for (int i = 0; i < 8; i++) push(16'(32'h1357 * i) ^ 16'hC001, acc);
    in_valid = 1'b0;
    wait_words(w0 + 8, 1000, "stream_timeout");
    repeat (DIV + 1) @(negedge CLK);
    check("stream_frame_done", 32'(fd_seen - fd0), 32'd2);
    check("stream_gap_entries", 32'(gap_log.size()), 32'd8);
    for (int i = 1; i < 8; i++) check("gap_len", 32'(gap_log[i]), (i == 4) ? 32'd1 : 32'd0);
    check("stream_word_cnt", 32'(word_cnt), 32'd0);

    // Full handshake while a word is shifting.
    do_reset();
    w0 = words_out;
    push(16'hBEEF, acc);
    in_valid = 1'b0;
    k = 0;
    while (!DEN && k < 20) begin
      @(posedge CLK); #1;
      k++;
    end
    check("den_up_before_burst", 32'(DEN), 32'd1);
    check("ready_before_burst", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      push(16'hA000 + 16'(i * 16'h0F1), acc_t[i]);
      if (i == 3) begin
        check("ready_when_full", 32'(in_ready), 32'd0);
        check("busy_when_full", 32'(busy), 32'd1);
      end
    end
    in_valid = 1'b0;
    check("burst_consecutive", 32'(acc_t[3] - acc_t[0]), 32'd3);
    check("burst_stall", 32'(acc_t[4] - acc_t[3] > 8), 32'd1);
    wait_words(w0 + 7, 1500, "burst_drain_timeout");
    idle(150);
    check("burst_word_total", 32'(words_out - w0), 32'd7);
    check("burst_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a word with another queued.
    do_reset();
    push(16'h6EC1, acc);
    push(16'h9B17, acc);
    in_valid = 1'b0;
    k = 0;
    while (mon_idx != 7 && k < 300) begin
      @(negedge CLK);
      k++;
    end
    check("reached_bit7", 32'(mon_idx), 32'd7);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_den", 32'(DEN), 32'd0);
    check("async_dai", 32'(DAI), 32'd0);
    check("async_dck", 32'(DCK), 32'd0);
    check("async_word_cnt", 32'(word_cnt), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    check("async_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge CLK);
    #2 rst_n = 1'b1;
    @(posedge CLK); #1;
    idle(10);
    w1 = words_out;
    push(16'h3C5A, acc);
    in_valid = 1'b0;
    wait_words(w1 + 1, 300, "post_reset_timeout");
    idle(150);
    check("post_reset_words", 32'(words_out - w1), 32'd1);
    check("post_reset_queue", 32'(exp_q.size()), 32'd0);

    // Random traffic scored by the monitor.
    do_reset();
    w0 = words_out;
    for (int i = 0; i < 24; i++) begin
      push(16'($urandom), acc);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 120)));
    end
    in_valid = 1'b0;
    wait_words(w0 + 24, 3000, "random_drain_timeout");
    idle(20);
    check("random_queue_empty", 32'(exp_q.size()), 32'd0);
    check("frame_done_total", 32'(fd_seen), 32'(exp_fd));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
